// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-control bundle: pipeline status in, fetch PC register inputs and stall/flush lines out.
// master = the controller that drives the PC inputs and stall/flush lines; slave = the pipeline side.
interface fetch_redirect_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_f;
    logic            imem_ready;
    logic            load_use_d;
    logic            redirect_e;
    logic [XLEN-1:0] redirect_target_e;

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_restore;
    logic            stallF;
    logic            flushF;
    logic            stallD;
    logic            flushD;
    logic            flushE;
    logic [31:0]     flush_count;
    logic [31:0]     stall_count;

    modport master (
        input  pc_f, imem_ready, load_use_d, redirect_e, redirect_target_e,
        output pc_next, pc_restore, stallF, flushF, stallD, flushD, flushE,
               flush_count, stall_count
    );

    modport slave (
        output pc_f, imem_ready, load_use_d, redirect_e, redirect_target_e,
        input  pc_next, pc_restore, stallF, flushF, stallD, flushD, flushE,
               flush_count, stall_count
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC redirect/stall/flush controller with boot restart and stale-response drain.
// Optional redirect/stall performance counters are built when HAZARD_PERF_EN is defined.
module fetch_redirect_ctrl #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_redirect_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] restore_q;
    logic [XLEN-1:0] target_aligned;
    logic            take_redirect;

    logic stall_f;
    logic flush_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;

    assign target_aligned = {bus.redirect_target_e[XLEN-1:2], 2'b00};
    assign take_redirect  = bus.redirect_e && (state != BOOT) && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            restore_q <= RESET_PC;
        end else begin
            state <= state_next;
            if (take_redirect) begin
                restore_q <= target_aligned;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        stall_f    = 1'b0;
        flush_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;

        unique case (state)
            BOOT: begin
                flush_f    = 1'b1;
                flush_d    = 1'b1;
                flush_e    = 1'b1;
                state_next = RUN;
            end
            RUN, DRAIN: begin
                if (bus.redirect_e) begin
                    flush_f    = 1'b1;
                    flush_d    = 1'b1;
                    flush_e    = 1'b1;
                    state_next = bus.imem_ready ? RUN : DRAIN;
                end else if (state == DRAIN) begin
                    // The response landing with imem_ready belongs to the squashed PC.
                    stall_f    = 1'b1;
                    flush_d    = 1'b1;
                    state_next = bus.imem_ready ? RUN : DRAIN;
                end else if (bus.load_use_d) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (!bus.imem_ready) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        if (rst) begin
            stall_f = 1'b0;
            flush_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end
    end

    assign bus.pc_next    = bus.pc_f + XLEN'(PC_STEP);
    assign bus.pc_restore = rst           ? RESET_PC :
                            take_redirect ? target_aligned : restore_q;
    assign bus.stallF     = stall_f;
    assign bus.flushF     = flush_f;
    assign bus.stallD     = stall_d;
    assign bus.flushD     = flush_d;
    assign bus.flushE     = flush_e;

`ifdef HAZARD_PERF_EN
    logic [31:0] flush_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (take_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (stall_f && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.flush_count = flush_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.flush_count = '0;
    assign bus.stall_count = '0;
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Control partner of the fetch PC register. It produces the fetch PC register's inputs: pc_next, pc_restore, stallF and flushF. It also produces the decode/execute stall and flush lines.
- Redirects: branch/jump resolved in EX.
- Stalls: load-use hazards flagged in ID, instruction-memory wait states.
- Stale returns: discards an instruction-memory response already in flight for a squashed PC.
- Boot: forces the post-reset restart PC.

Parameters:
XLEN, 32, PC and target width.
RESET_PC, 32'h0000_0000, PC loaded via flushF in the first cycle after reset.
PC_STEP, 4, sequential fetch increment.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
pc_f  in  XLEN  current fetch PC (fetch register output).
imem_ready  in  1  instruction memory returns the fetch for pc_f this cycle.
load_use_d  in  1  load-use hazard detected in ID.
redirect_e  in  1  EX resolved taken branch/jump (mispredict vs. fall-through).
redirect_target_e  in  XLEN  redirect destination.
pc_next  out  XLEN  sequential next PC.
pc_restore  out  XLEN  PC loaded when flushF=1.
stallF  out  1  hold fetch PC.
flushF  out  1  load pc_restore into fetch PC (overrides stallF downstream).
stallD  out  1  hold IF/ID register.
flushD  out  1  clear IF/ID register to bubble.
flushE  out  1  clear ID/EX register to bubble.
flush_count  out  32  redirect count (optional feature).
stall_count  out  32  stall-cycle count (optional feature).

Behaviour:
- pc_next = pc_f + PC_STEP, modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), in every state.
- pc_restore:
  - redirect_e=1: redirect_target_e with bits [1:0] forced to 0.
  - Otherwise: the last restored value; RESET_PC after reset.
- FSM state is registered; all stall/flush outputs are combinational from state and inputs.
- States are BOOT, RUN and DRAIN.
- While rst=1: state<=BOOT, pc_restore=RESET_PC, all stall/flush outputs 0, counters cleared. Reset mid-DRAIN abandons the drain.
- BOOT lasts exactly one cycle and ignores all inputs:
  - flushF=1, flushD=1, flushE=1, pc_restore=RESET_PC.
  - Next state is RUN.
- Priority in RUN and DRAIN, highest first:
  1. redirect_e=1 (either state): flushF=1, flushD=1, flushE=1, stallF=0, stallD=0.
     - Next state DRAIN if imem_ready=0, else RUN.
     - A redirect while already in DRAIN reloads pc_restore and stays in DRAIN.
  2. DRAIN with no redirect: stallF=1, flushD=1.
     - The response arriving in the imem_ready=1 cycle is the stale fetch; flushD discards it.
     - Next state RUN on imem_ready=1, else stay in DRAIN.
  3. RUN, load_use_d=1: stallF=1, stallD=1, flushE=1, regardless of imem_ready.
  4. RUN, imem_ready=0: stallF=1, flushD=1 (bubble into ID).
  5. Otherwise all stall/flush outputs are 0.
- Invariants:
  - flushF and stallF are never both 1.
  - stallD and flushD are never both 1.
- Latency: redirect-to-flushF is 0 cycles (same cycle). The first correct-path instruction reaches ID no earlier than 1 cycle after the redirect.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - flush_count increments on each cycle with redirect_e=1 outside BOOT.
  - stall_count increments on each cycle with stallF=1.
  - Both saturate at 0xFFFF_FFFF and clear on rst.
- Undefined: the counters are not built; flush_count and stall_count are tied to 0.

Test Plan:
- Boot: release rst -> next cycle flushF=1, pc_restore=RESET_PC, flushD=flushE=1; the following cycle is RUN with all controls 0 and pc_next = pc_f + 4.
- Wrap: pc_f=0xFFFF_FFFC, imem_ready=1 -> pc_next=0x0000_0000, no stall.
- Load-use: load_use_d=1 for 1 cycle, imem_ready=1 -> stallF=stallD=flushE=1 that cycle only; flushF=flushD=0.
- Redirect while memory busy:
  - Stimulus: redirect_e=1, target 0x0000_1236, imem_ready=0.
  - Same cycle: flushF=1, pc_restore=0x0000_1234.
  - Then: 2 DRAIN cycles with stallF=flushD=1; imem_ready=1 on the 2nd DRAIN cycle keeps flushD=1.
  - Next cycle: RUN.
- Simultaneous redirect and load_use_d in RUN -> redirect wins: flushF=flushD=flushE=1, stallF=stallD=0.
- HAZARD_PERF_EN: 3 redirects plus 5 stall cycles -> flush_count=3, stall_count includes all stallF cycles; rst mid-run -> both 0 next cycle, state BOOT.
